// File: rtl/regfile_dump_unit_pkg.sv
// Shared definitions for the MIPS debug read path: datapath width,
// byte width and the dump FSM state type.
`ifndef LEN
`define LEN 32
`endif

package regfile_dump_unit_pkg;

  localparam int unsigned default_len = `LEN;
  localparam int unsigned byte_w      = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_unit_word_serializer.sv
// Splits one len-bit word into bytes, least significant byte first, and
// presents them on a valid/ready byte stream.
module regfile_dump_unit_word_serializer
  import regfile_dump_unit_pkg::*;
#(
  parameter int unsigned len = default_len
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [len-1:0]    load_data,
  input  logic              tx_ready,
  output logic [byte_w-1:0] tx_data,
  output logic              tx_valid,
  output logic              last_accept
);

  localparam int unsigned nb_bytes = len / byte_w;
  localparam int unsigned cnt_w    = (nb_bytes > 1) ? $clog2(nb_bytes) : 1;

  logic [len-1:0]   shift;
  logic [cnt_w-1:0] cnt;
  logic             accept;

  assign accept      = tx_valid && tx_ready;
  assign last_accept = accept && (cnt == cnt_w'(nb_bytes - 1));
  assign tx_data     = shift[byte_w-1:0];

  // Load a fresh word, then shift one byte out per accepted handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift    <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shift    <= load_data;
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (accept) begin
      shift <= shift >> byte_w;
      if (last_accept) begin
        cnt      <= '0;
        tx_valid <= 1'b0;
      end else begin
        cnt <= cnt + cnt_w'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_dump_unit.sv
// Debug-side register file reader: on start, walks registers 0..nregs-1
// over the debug read port and streams each word out as bytes. busy
// freezes the pipeline (and so the register file) for the whole dump.
module regfile_dump_unit
  import regfile_dump_unit_pkg::*;
#(
  parameter int unsigned len   = default_len,
  parameter int unsigned nregs = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [$clog2(nregs)-1:0] reg_addr,
  input  logic [len-1:0]           reg_data,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned addr_w = $clog2(nregs);
  localparam logic [addr_w-1:0] last_addr = addr_w'(nregs - 1);

  dump_state_t state;
  logic        load;
  logic        last_accept;

  // The register file presents data for reg_addr one cycle after ADDR,
  // so the word is captured while in WAIT.
  assign load = (state == WAIT);

  regfile_dump_unit_word_serializer #(
    .len (len)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_data   (reg_data),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .last_accept (last_accept)
  );

  // Dump sequencing: register walk, busy window and the done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      reg_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ADDR;
            reg_addr <= '0;
            busy     <= 1'b1;
          end
        end
        ADDR: state <= WAIT;
        WAIT: state <= SEND;
        SEND: begin
          if (last_accept) begin
            if (reg_addr == last_addr) begin
              state <= DONE;
            end else begin
              reg_addr <= reg_addr + addr_w'(1);
              state    <= ADDR;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          reg_addr <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: behavioural register file, byte-stream
// monitor and a table of dump scenarios checked against an expected byte
// list built directly from the register contents.
module tb_regfile_dump_unit;

  localparam int unsigned len         = 32;
  localparam int unsigned nregs       = 32;
  localparam int unsigned nb          = len / 8;
  localparam int unsigned total       = nregs * nb;
  localparam int          base_cycles = 193;

  typedef struct {
    int ready_mode;     // 0 always ready, 1 pattern 1,0,0, 2 random
    bit rand_data;
    int restart_a;      // byte count at which start is re-pulsed, -1 none
    int restart_b;
    bit start_in_done;
    int exp_cycles;     // start-to-done cycles, -1 means "later than base"
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [nregs];

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode  = 0;
  int ready_phase = 0;

  bit         mon_en = 1'b0;
  logic [7:0] got [$];
  int         done_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  regfile_dump_unit #(
    .len   (len),
    .nregs (nregs)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Register file debug read port: registered, one cycle of latency.
  always @(posedge clk) reg_data <= rf[reg_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor: records accepted bytes, checks hold-under-stall, counts done.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall)
        check("hold_stable", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, prev_data});
      if (reset && tx_valid && tx_ready) got.push_back(tx_data);
      if (done) done_cnt++;
      prev_stall = reset && tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: begin
        tx_ready    = (ready_phase == 0);
        ready_phase = (ready_phase + 1) % 3;
      end
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic fill_rf(input bit rnd);
    for (int i = 0; i < int'(nregs); i++) begin
      if (rnd) rf[i] = $urandom;
      else if (i == 0) rf[i] = 32'h4;
      else if (i == 1) rf[i] = 32'h7;
      else rf[i] = 32'(i) * 32'h01010101;
    end
  endtask

  task automatic run_dump(input vec_t v, input int idx);
    logic [7:0] exp_q [$];
    int cycles;
    int busy_drop;
    bit ra;
    bit rb;
    string tag;
    tag = $sformatf("dump%0d", idx);
    ready_mode  = v.ready_mode;
    ready_phase = 0;
    fill_rf(v.rand_data);
    exp_q = {};
    for (int i = 0; i < int'(nregs); i++)
      for (int b = 0; b < int'(nb); b++)
        exp_q.push_back(rf[i][8*b +: 8]);
    got = {};
    done_cnt = 0;
    mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    busy_drop = 0;
    ra = 1'b0;
    rb = 1'b0;
    while (!done && cycles < 4000) begin
      tick();
      cycles++;
      start = 1'b0;
      if (!done && !busy) busy_drop++;
      if (v.restart_a >= 0 && !ra && got.size() >= v.restart_a) begin
        start = 1'b1;
        ra = 1'b1;
      end
      if (v.restart_b >= 0 && !rb && got.size() >= v.restart_b) begin
        start = 1'b1;
        rb = 1'b1;
      end
      if (v.start_in_done && cycles == base_cycles - 1) start = 1'b1;
    end
    start = 1'b0;
    check($sformatf("%s_done_seen", tag), {63'd0, done}, 64'd1);
    if (v.exp_cycles >= 0)
      check($sformatf("%s_latency", tag), cycles, v.exp_cycles);
    else
      check($sformatf("%s_slower", tag), {63'd0, cycles > base_cycles}, 64'd1);
    repeat (12) tick();
    mon_en = 1'b0;
    check($sformatf("%s_nbytes", tag), got.size(), total);
    for (int i = 0; i < int'(total); i++)
      check($sformatf("%s_byte%0d", tag, i),
            {56'd0, (i < got.size()) ? got[i] : 8'hxx}, {56'd0, exp_q[i]});
    check($sformatf("%s_done_count", tag), done_cnt, 1);
    check($sformatf("%s_busy_gap", tag), busy_drop, 0);
    check($sformatf("%s_idle_after", tag), {62'd0, busy, tx_valid}, 64'd0);
  endtask

  initial begin
    vec_t vecs [5];
    int cyc;
    vecs[0] = '{0, 1'b0, -1,  -1,  1'b0, base_cycles};
    vecs[1] = '{1, 1'b0, -1,  -1,  1'b0, -1};
    vecs[2] = '{0, 1'b0, 10,  125, 1'b0, base_cycles};
    vecs[3] = '{0, 1'b1, -1,  -1,  1'b1, base_cycles};
    vecs[4] = '{2, 1'b1, 10,  126, 1'b0, -1};

    reset = 1'b0;
    start = 1'b1;
    tx_ready = 1'b1;
    ready_mode = 0;
    fill_rf(1'b0);

    // Reset held with start asserted.
    repeat (3) tick();
    check("rst_reg_addr", reg_addr, 0);
    check("rst_tx_data",  tx_data,  0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_no_start", {61'd0, busy, tx_valid, done}, 64'd0);
    end

    // Start-to-first-byte latency and address advance.
    mon_en = 1'b1;
    got = {};
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_k_addr",  reg_addr, 0);
    check("lat_k_busy",  busy,     1);
    check("lat_k_valid", tx_valid, 0);
    tick();
    check("lat_k1_valid", tx_valid, 0);
    tick();
    check("lat_k2_valid", tx_valid, 1);
    check("lat_k2_data",  tx_data,  8'h04);
    repeat (3) tick();
    check("lat_k5_addr", reg_addr, 0);
    tick();
    check("lat_k6_addr",  reg_addr, 1);
    check("lat_k6_valid", tx_valid, 0);
    check("lat_r0_bytes", got.size(), 4);

    // Reset mid-dump after 50 bytes.
    cyc = 0;
    while (got.size() < 50 && cyc < 500) begin
      tick();
      cyc++;
    end
    check("mid_reach50", got.size(), 50);
    reset = 1'b0;
    tick();
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy",  busy,     0);
    reset = 1'b1;
    repeat (20) tick();
    check("mid_no_done",   done_cnt,   0);
    check("mid_no_bytes",  got.size(), 50);
    check("mid_idle",      {62'd0, busy, tx_valid}, 64'd0);
    mon_en = 1'b0;

    for (int i = 0; i < 5; i++) run_dump(vecs[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
- Debug-side reader for the MIPS decode-stage register file. It is the read counterpart of the RegWrite/write_register/write_data write port.
- On a start pulse it walks registers 0..nregs-1 through a dedicated debug read port and serialises each word into bytes. Bytes leave over a valid/ready byte stream to the UART transmitter of the debug unit.
- busy stalls the pipeline so the register file is frozen during the dump.

Parameters:
- len, 32, register width in bits (multiple of 8)
- nregs, 32, number of registers dumped
- nb_bytes, len/8, bytes per register (derived, localparam)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to begin a dump
- reg_addr  out  $clog2(nregs)  debug read address to register file
- reg_data  in  len  register file debug read data, valid one cycle after reg_addr
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte this cycle
- busy  out  1  dump in progress; drives pipeline stall
- done  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE, reg_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, byte counter=0, shift register=0. Reset has priority over every other input.
- FSM states: IDLE, ADDR, WAIT, SEND, DONE.
- IDLE:
  - start==1 -> ADDR, reg_addr=0, busy=1.
  - start==0 -> stay in IDLE.
- ADDR -> WAIT unconditionally. reg_addr is held; the register file registers the read.
- WAIT: capture reg_data into the len-bit shift register, byte counter=0, set tx_valid=1, go to SEND.
- SEND:
  - tx_data = shift[7:0]. Byte order is little-endian: bits [7:0] first, [len-1:len-8] last.
  - On tx_valid && tx_ready:
    - shift right 8, counter+1.
    - If counter was nb_bytes-1: tx_valid=0.
      - If reg_addr==nregs-1 -> DONE.
      - Else reg_addr+1 -> ADDR.
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable with no state change.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. reg_addr returns to 0.
- Latency:
  - start sampled at edge k: first tx_valid=1 after edge k+2.
  - Each register costs 2 + nb_bytes cycles with tx_ready tied high.
  - Full dump with tx_ready=1: start to done = nregs*(2+nb_bytes)+1 cycles (193 for defaults).
- start while busy (any state except IDLE) is ignored, with no restart or counter disturbance.
- start in the same cycle as the DONE state is ignored. A new dump needs start while in IDLE.
- Reset asserted mid-dump aborts the dump:
  - tx_valid=0 after that edge.
  - No done pulse.
  - Next start begins again at register 0.
- reg_addr wrap: it never exceeds nregs-1, and the counter must not overflow when nregs is a power of two.
- Exactly nregs*nb_bytes handshakes per completed dump.

Decomposition:
- Shared package/header for the MIPS debug path:
  - FSM state encodings (IDLE, ADDR, WAIT, SEND, DONE) as localparams
  - byte width 8
  - the `LEN width define already used by the MIPS stages
- One natural sub-module: word_serializer. It handles load, shift and the byte counter with the valid/ready handshake, parameterised by len.
- The FSM and register walk stay in regfile_dump_unit.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with start=1 -> all outputs 0, no tx_valid. Release reset -> remains IDLE until a fresh start.
- Full dump with tx_ready=1:
  - Preload r0=0x4, r1=0x7, ri=i*0x01010101 for i>=2.
  - Pulse start -> byte stream 04 00 00 00 07 00 00 00 02 02 02 02 ... 1F 1F 1F 1F.
  - 128 handshakes, done pulse 193 cycles after start, busy high throughout.
- Backpressure: tx_ready toggling 1,0,0,1,... -> tx_data/tx_valid stable whenever tx_ready=0. Byte sequence is identical to the previous scenario; done arrives later; no byte is lost or duplicated.
- start re-pulsed at byte 10 and again in SEND of r31 -> ignored; single 128-byte stream; single done pulse.
- Reset mid-dump at byte 50 -> tx_valid=0 and busy=0 next cycle, no done. Subsequent start -> stream restarts with 04 00 00 00.
- Latency check: start at edge k -> reg_addr=0 after k, tx_valid=1 after k+2. After r0's 4th handshake, reg_addr=1 on the next edge.
